// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding
// and the source-index to vector mapping.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLD
    } intr_state_t;

    localparam logic [31:0] VEC_STRIDE = 32'd4;

    // Vector for source idx; the caller truncates to its own vector width.
    function automatic logic [31:0] vec_of(input logic [31:0] base, input logic [31:0] idx);
        return base + VEC_STRIDE * idx;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the index of
// the lowest set bit.
module intr_prio_enc #(
    parameter int NREQ = 8,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  bits,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        any = |bits;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bits[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/intr_ctl.sv
// Interrupt controller: edge-captures requests into a pending register,
// masks and arbitrates them, and runs the sintr/ack handshake with the CPU.
module intr_ctl
    import intr_pkg::*;
#(
    parameter int               NREQ     = 8,
    parameter int               VEC_W    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = 8'h40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             mask_we,
    input  logic [NREQ-1:0]  mask_wdata,
    input  logic [NREQ-1:0]  swclr,
    input  logic             ack,
    output logic             sintr,
    output logic [VEC_W-1:0] vector,
    output logic [NREQ-1:0]  pending,
    output logic [NREQ-1:0]  mask
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    intr_state_t      state, state_nxt;
    logic [NREQ-1:0]  req_d;
    logic [NREQ-1:0]  set_term;
    logic [NREQ-1:0]  ackclr;
    logic [NREQ-1:0]  pending_nxt;
    logic [NREQ-1:0]  cand;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             load_cur;
    logic [31:0]      vec_full;

    assign set_term = req & ~req_d;
    assign cand     = pending & ~mask;
    assign vec_full = vec_of(32'(VEC_BASE), 32'(win_idx));

    intr_prio_enc #(.NREQ(NREQ)) u_prio (
        .bits (cand),
        .any  (win_any),
        .idx  (win_idx)
    );

    // The acknowledge retires cur even if that bit was already cleared or
    // masked meanwhile; set is OR-ed in last so a new edge always survives.
    always_comb begin
        ackclr = '0;
        if (state == ASSERT && ack) ackclr[cur] = 1'b1;
        pending_nxt = set_term | (pending & ~swclr & ~ackclr);
    end

    always_comb begin
        state_nxt = state;
        load_cur  = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_nxt = ASSERT;
                    load_cur  = 1'b1;
                end
            end
            ASSERT:  if (ack) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sintr   <= 1'b0;
            vector  <= VEC_BASE;
            cur     <= '0;
            pending <= '0;
            mask    <= '1;
            req_d   <= '0;
        end else begin
            state   <= state_nxt;
            sintr   <= (state_nxt == ASSERT);
            req_d   <= req;
            pending <= pending_nxt;
            if (mask_we) mask <= mask_wdata;
            if (load_cur) begin
                cur    <= win_idx;
                vector <= vec_full[VEC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_intr_ctl.sv
// Self-checking bench for intr_ctl: expected vectors are queued when
// requests are driven and compared whenever sintr rises.
module tb_intr_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] swclr;
    logic       ack;
    logic       sintr;
    logic [7:0] vector;
    logic [7:0] pending;
    logic [7:0] mask;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic       sintr_q = 1'b0;
    logic [7:0] held_vec = 8'h00;

    always #5 clk = ~clk;

    intr_ctl #(.NREQ(8), .VEC_W(8), .VEC_BASE(8'h40)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .swclr      (swclr),
        .ack        (ack),
        .sintr      (sintr),
        .vector     (vector),
        .pending    (pending),
        .mask       (mask)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sintr(input int budget);
        for (int i = 0; i < budget && sintr !== 1'b1; i++) tick();
        check("sintr_wait", 32'(sintr), 32'd1);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("sintr_after_ack", 32'(sintr), 32'd0);
    endtask

    // Scoreboard: each sintr rising edge pops one expected vector; the
    // vector must then hold steady while sintr stays high.
    always @(negedge clk) begin
        if (sintr === 1'b1 && sintr_q !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sintr", 32'(sintr), 32'd0);
            end else begin
                check("vector", 32'(vector), 32'(exp_q.pop_front()));
            end
            held_vec = vector;
        end else if (sintr === 1'b1) begin
            check("vector_stable", 32'(vector), 32'(held_vec));
        end
        sintr_q = sintr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req        = 8'hFF;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        swclr      = 8'h00;
        ack        = 1'b0;

        // 1. Reset values, then the held-high lines register on release.
        repeat (3) tick();
        check("rst_sintr", 32'(sintr), 32'd0);
        check("rst_mask", 32'(mask), 32'hFF);
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_vector", 32'(vector), 32'h40);
        reset = 1'b0;
        tick();
        check("post_rst_pending", 32'(pending), 32'hFF);
        check("post_rst_sintr", 32'(sintr), 32'd0);
        req   = 8'h00;
        swclr = 8'hFF;
        tick();
        swclr = 8'h00;
        check("swclr_pending", 32'(pending), 32'h00);

        // 2. Single source.
        mask_we    = 1'b1;
        mask_wdata = 8'h00;
        tick();
        mask_we = 1'b0;
        check("mask_write", 32'(mask), 32'h00);
        req = 8'h08;
        exp_q.push_back(8'h4C);
        tick();
        req = 8'h00;
        check("src3_pending", 32'(pending), 32'h08);
        check("src3_not_yet", 32'(sintr), 32'd0);
        tick();
        check("src3_sintr", 32'(sintr), 32'd1);
        check("src3_vector", 32'(vector), 32'h4C);
        ack_pulse();
        check("src3_cleared", 32'(pending), 32'h00);
        tick();
        check("src3_gap1", 32'(sintr), 32'd0);
        tick();
        check("src3_gap2", 32'(sintr), 32'd0);

        // 3. Priority: source 2 before source 5, two low cycles between.
        req = 8'h24;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h54);
        tick();
        req = 8'h00;
        wait_sintr(10);
        check("prio_first", 32'(vector), 32'h48);
        ack_pulse();
        tick();
        check("prio_hold_low", 32'(sintr), 32'd0);
        tick();
        check("prio_second_sintr", 32'(sintr), 32'd1);
        check("prio_second", 32'(vector), 32'h54);
        ack_pulse();

        // 4. No preemption of an active service.
        req = 8'h10;
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h40);
        tick();
        req = 8'h00;
        wait_sintr(10);
        req = 8'h01;
        tick();
        req = 8'h00;
        repeat (2) tick();
        check("nopre_sintr", 32'(sintr), 32'd1);
        check("nopre_vector", 32'(vector), 32'h50);
        check("nopre_pending", 32'(pending), 32'h11);
        ack_pulse();
        wait_sintr(10);
        check("nopre_next", 32'(vector), 32'h40);
        ack_pulse();

        // 5. New edge on the served source in the same cycle as ack.
        req = 8'h02;
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        tick();
        req = 8'h00;
        wait_sintr(10);
        req = 8'h02;
        ack = 1'b1;
        tick();
        req = 8'h00;
        ack = 1'b0;
        check("setwins_pending", 32'(pending), 32'h02);
        wait_sintr(10);
        check("setwins_vector", 32'(vector), 32'h44);
        ack_pulse();
        check("setwins_cleared", 32'(pending), 32'h00);

        // 6. Masked pending source, then unmask, then reset in ASSERT.
        mask_we    = 1'b1;
        mask_wdata = 8'h40;
        req        = 8'h40;
        tick();
        mask_we = 1'b0;
        req     = 8'h00;
        repeat (4) tick();
        check("masked_sintr", 32'(sintr), 32'd0);
        check("masked_pending", 32'(pending), 32'h40);
        exp_q.push_back(8'h58);
        mask_we    = 1'b1;
        mask_wdata = 8'h00;
        tick();
        mask_we = 1'b0;
        wait_sintr(10);
        check("unmask_vector", 32'(vector), 32'h58);
        reset = 1'b1;
        tick();
        check("midrst_sintr", 32'(sintr), 32'd0);
        check("midrst_pending", 32'(pending), 32'h00);
        check("midrst_mask", 32'(mask), 32'hFF);
        check("midrst_vector", 32'(vector), 32'h40);
        reset = 1'b0;
        repeat (3) tick();
        check("post_midrst_sintr", 32'(sintr), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
